// File: rtl/ship_hit_controller_pkg.sv
// Shared game geometry for the collision checkers: ship hitbox row and
// tolerances, plus the clamped lower-bound helper used by window compares.
package ship_hit_controller_pkg;

  localparam int COORD_W = 11;
  localparam int WIN_W   = 12;

  localparam logic [WIN_W-1:0] Y_SHIP  = 12'd680;
  localparam logic [WIN_W-1:0] Y_TOL   = 12'd4;
  localparam logic [WIN_W-1:0] X_WIDTH = 12'd10;

  // Lower window bound saturates at 0 so ships near the left edge never wrap.
  function automatic logic [WIN_W-1:0] win_lo(input logic [WIN_W-1:0] centre,
                                              input logic [WIN_W-1:0] tol);
    return (centre > tol) ? (centre - tol) : '0;
  endfunction

endpackage

// File: rtl/ship_hit_controller_hitbox_cmp.sv
// Combinational ship hitbox test: inclusive X/Y window around the ship,
// evaluated at 12 bits with a clamped lower bound and an unclamped upper bound.
module ship_hit_controller_hitbox_cmp
  import ship_hit_controller_pkg::*;
(
  input  logic [COORD_W-1:0] i_ship_x,
  input  logic [COORD_W-1:0] i_bul_x,
  input  logic [COORD_W-1:0] i_bul_y,
  output logic               o_hit
);

  logic [WIN_W-1:0] w_bx;
  logic [WIN_W-1:0] w_by;
  logic [WIN_W-1:0] w_sx;
  logic [WIN_W-1:0] w_x_lo;
  logic [WIN_W-1:0] w_x_hi;
  logic [WIN_W-1:0] w_y_lo;
  logic [WIN_W-1:0] w_y_hi;

  always_comb begin
    w_bx   = {1'b0, i_bul_x};
    w_by   = {1'b0, i_bul_y};
    w_sx   = {1'b0, i_ship_x};
    w_x_lo = win_lo(w_sx, X_WIDTH);
    w_x_hi = w_sx + X_WIDTH;
    w_y_lo = win_lo(Y_SHIP, Y_TOL);
    w_y_hi = Y_SHIP + Y_TOL;
    o_hit  = (w_bx >= w_x_lo) && (w_bx <= w_x_hi) &&
             (w_by >= w_y_lo) && (w_by <= w_y_hi);
  end

endmodule

// File: rtl/ship_hit_controller.sv
// Per-frame ship-vs-enemy-bullet scheduler: scans every bullet slot after each
// frame tick, kills overlapping bullets, and tracks lives, invulnerability and blink.
module ship_hit_controller
  import ship_hit_controller_pkg::*;
#(
  parameter int N_BULLETS     = 8,
  parameter int IDX_W         = 3,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               game_restart,
  input  logic [COORD_W-1:0] ship_X,
  output logic               bul_rd,
  output logic [IDX_W-1:0]   bul_idx,
  input  logic               bul_valid,
  input  logic [COORD_W-1:0] bul_X,
  input  logic [COORD_W-1:0] bul_Y,
  output logic               bul_kill,
  output logic [IDX_W-1:0]   bul_kill_idx,
  output logic               ship_hit,
  output logic [2:0]         lives,
  output logic               is_ship_display,
  output logic               game_over
);

  localparam int INV_W = $clog2(INVULN_FRAMES + 1);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_BULLETS - 1);
  localparam logic [INV_W-1:0] INVULN_INIT = INV_W'(INVULN_FRAMES);
  localparam logic [BLK_W-1:0] BLINK_LAST  = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [2:0]       LIVES_INIT  = 3'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_APPLY,
    S_OVER
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_chk_vld;
  logic [IDX_W-1:0]     r_chk_idx;
  logic [COORD_W-1:0]   r_ship_x;
  logic                 r_hit_flag;
  logic [2:0]           r_lives;
  logic [INV_W-1:0]     r_invuln;
  logic [BLK_W-1:0]     r_blink;
  logic                 r_display;
  logic                 w_in_box;
  logic                 w_kill;

  ship_hit_controller_hitbox_cmp u_hitbox (
    .i_ship_x (r_ship_x),
    .i_bul_x  (bul_X),
    .i_bul_y  (bul_Y),
    .o_hit    (w_in_box)
  );

  // Read data for the slot issued last cycle is on bul_* now; rst suppresses
  // any pulse in the very cycle it is asserted.
  always_comb begin
    w_kill = r_chk_vld && bul_valid && w_in_box && (r_invuln == '0) && !rst;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (frame_tick) w_state_next = S_SCAN;
      S_SCAN:  if (r_idx == IDX_LAST) w_state_next = S_DRAIN;
      S_DRAIN: w_state_next = S_APPLY;
      S_APPLY: begin
        if (r_hit_flag && (r_lives == 3'd1)) w_state_next = S_OVER;
        else                                 w_state_next = S_IDLE;
      end
      S_OVER:  if (game_restart) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_chk_vld  <= 1'b0;
      r_chk_idx  <= '0;
      r_ship_x   <= '0;
      r_hit_flag <= 1'b0;
      r_lives    <= LIVES_INIT;
      r_invuln   <= '0;
      r_blink    <= '0;
      r_display  <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_chk_vld <= (r_state == S_SCAN);
      if (r_state == S_SCAN) r_chk_idx <= r_idx;

      case (r_state)
        S_IDLE: begin
          if (frame_tick) begin
            r_ship_x   <= ship_X;
            r_hit_flag <= 1'b0;
            r_idx      <= '0;
          end
        end
        S_SCAN:  r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        default: ;
      endcase

      if (w_kill) r_hit_flag <= 1'b1;

      // A hit in APPLY outranks ageing from a coincident tick; OVER freezes everything.
      if ((r_state == S_APPLY) && r_hit_flag) begin
        r_lives   <= r_lives - 3'd1;
        r_invuln  <= INVULN_INIT;
        r_blink   <= '0;
        r_display <= 1'b0;
      end else if (r_state == S_OVER) begin
        if (game_restart) begin
          r_lives   <= LIVES_INIT;
          r_invuln  <= '0;
          r_blink   <= '0;
          r_display <= 1'b1;
        end
      end else if (frame_tick && (r_invuln != '0)) begin
        r_invuln <= r_invuln - INV_W'(1);
        if (r_blink == BLINK_LAST) begin
          r_blink   <= '0;
          r_display <= !r_display;
        end else begin
          r_blink <= r_blink + BLK_W'(1);
        end
        if (r_invuln == INV_W'(1)) r_display <= 1'b1;
      end
    end
  end

  always_comb begin
    bul_rd          = (r_state == S_SCAN);
    bul_idx         = r_idx;
    bul_kill        = w_kill;
    bul_kill_idx    = r_chk_idx;
    ship_hit        = (r_state == S_APPLY) && r_hit_flag && !rst;
    lives           = r_lives;
    is_ship_display = r_display && (r_state != S_OVER);
    game_over       = (r_state == S_OVER);
  end

endmodule
